// File: rtl/temp_ctrl_pkg.sv
// Shared thermostat definitions: panel status codes and the controller state encoding.
// Imported by temp_controller and by the display panel.
package temp_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_HEAT  = 2'b01;
  localparam logic [1:0] ST_COOL  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StHeat,
    StCool,
    StError
  } state_e;

  function automatic logic [1:0] status_of(state_e s);
    logic [1:0] code;
    unique case (s)
      StIdle:  code = ST_IDLE;
      StHeat:  code = ST_HEAT;
      StCool:  code = ST_COOL;
      default: code = ST_ERROR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Load/decrement-to-zero counter: load sets Count-1, then counts down and holds at zero.
// Used to enforce the minimum time spent in any thermostat state.
module dwell_timer #(
  parameter int unsigned Count = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int unsigned W = (Count > 1) ? $clog2(Count) : 1;
  localparam logic [W-1:0] LoadVal = W'(Count - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/temp_controller.sv
// Greenhouse thermostat sequencer: hysteresis thresholds, minimum-dwell anti-short-cycle
// timer and a sensor watchdog that forces a latched error state.
module temp_controller
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned TEMP_W         = 8,
  parameter int unsigned HYST           = 2,
  parameter int unsigned MIN_DWELL      = 50_000_000,
  parameter int unsigned SENSOR_TIMEOUT = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic              error_clear,
  output logic [1:0]        status,
  output logic              heater_on,
  output logic              cooler_on,
  output logic              dwell_active
);

  localparam int unsigned WdW = (SENSOR_TIMEOUT > 1) ? $clog2(SENSOR_TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(SENSOR_TIMEOUT - 1);
  localparam logic [TEMP_W:0] HystExt = (TEMP_W + 1)'(HYST);
  localparam logic [TEMP_W:0] TempMax = {1'b0, {TEMP_W{1'b1}}};

  state_e            state_q, state_d;
  logic [TEMP_W-1:0] temp_reg_q, temp_reg_d;
  logic              have_sample_q, have_sample_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [1:0]        status_q, status_d;
  logic              heater_q, heater_d;
  logic              cooler_q, cooler_d;

  logic [TEMP_W:0] temp_ext, sp_ext, sum, lo, hi;
  logic            dwell_zero;
  logic            dwell_load;
  logic            timeout;
  logic            go;

  // Thresholds in TEMP_W+1 bits so the saturation checks cannot wrap.
  always_comb begin
    temp_ext = {1'b0, temp_reg_q};
    sp_ext   = {1'b0, setpoint};
    sum      = sp_ext + HystExt;
    hi       = (sum > TempMax) ? TempMax : sum;
    lo       = (sp_ext >= HystExt) ? (sp_ext - HystExt) : '0;
  end

  always_comb begin
    temp_reg_d = temp_valid ? temp_in : temp_reg_q;
  end

  // Watchdog: a valid sample in the final count cycle wins over the timeout.
  always_comb begin
    wd_d = wd_q;
    if (temp_valid) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  assign timeout = (wd_q == WdMax) && !temp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    go      = have_sample_q && dwell_zero;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (temp_ext < lo) begin
            state_d = StHeat;
          end else if (temp_ext > hi) begin
            state_d = StCool;
          end
        end
      end
      StHeat: begin
        if (go && (temp_ext >= sp_ext)) begin
          state_d = StIdle;
        end
      end
      StCool: begin
        if (go && (temp_ext <= sp_ext)) begin
          state_d = StIdle;
        end
      end
      StError: begin
        if (error_clear && have_sample_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      state_d = StError;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the FSM.
  always_comb begin
    status_d = status_of(state_d);
    heater_d = (state_d == StHeat);
    cooler_d = (state_d == StCool);
  end

  // Entering ERROR forces a fresh sample before the operator may clear it.
  always_comb begin
    have_sample_d = have_sample_q;
    if ((state_d == StError) && (state_q != StError)) begin
      have_sample_d = 1'b0;
    end else if (temp_valid) begin
      have_sample_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_reg_q    <= '0;
      have_sample_q <= 1'b0;
      wd_q          <= '0;
      status_q      <= ST_IDLE;
      heater_q      <= 1'b0;
      cooler_q      <= 1'b0;
    end else begin
      temp_reg_q    <= temp_reg_d;
      have_sample_q <= have_sample_d;
      wd_q          <= wd_d;
      status_q      <= status_d;
      heater_q      <= heater_d;
      cooler_q      <= cooler_d;
    end
  end

  assign dwell_load = (state_d != state_q);

  dwell_timer #(
    .Count(MIN_DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (reset),
    .load(dwell_load),
    .zero(dwell_zero)
  );

  assign status       = status_q;
  assign heater_on    = heater_q;
  assign cooler_on    = cooler_q;
  assign dwell_active = !dwell_zero;

endmodule

// File: tb/tb_temp_controller.sv
// Directed bench for temp_controller: table of single-sample steps plus hand-timed
// sequences for dwell, watchdog timeout, error clear and mid-run reset.
module tb_temp_controller;

  logic       clk;
  logic       reset;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic [7:0] setpoint;
  logic       error_clear;
  logic [1:0] status;
  logic       heater_on;
  logic       cooler_on;
  logic       dwell_active;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] temp;
    logic [7:0] sp;
    logic [1:0] st;
    logic       heat;
    logic       cool;
  } vec_t;

  vec_t vecs[15];

  temp_controller #(
    .TEMP_W        (8),
    .HYST          (2),
    .MIN_DWELL     (4),
    .SENSOR_TIMEOUT(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .temp_in     (temp_in),
    .temp_valid  (temp_valid),
    .setpoint    (setpoint),
    .error_clear (error_clear),
    .status      (status),
    .heater_on   (heater_on),
    .cooler_on   (cooler_on),
    .dwell_active(dwell_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Valid strobe for one cycle; setpoint changes together with the new temp_reg.
  task automatic pulse(input logic [7:0] t, input logic [7:0] sp);
    @(negedge clk);
    temp_in    = t;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    setpoint   = sp;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] st, input logic h,
                           input logic c);
    check({name, ".status"}, {30'd0, status}, {30'd0, st});
    check({name, ".heater"}, {31'd0, heater_on}, {31'd0, h});
    check({name, ".cooler"}, {31'd0, cooler_on}, {31'd0, c});
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: run did not finish, got no $finish, expected $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // temp, setpoint, status, heater, cooler; each step starts from the previous outcome
    vecs[0]  = '{8'd73,  8'd70,  2'b10, 1'b0, 1'b1};
    vecs[1]  = '{8'd71,  8'd70,  2'b10, 1'b0, 1'b1};
    vecs[2]  = '{8'd70,  8'd70,  2'b00, 1'b0, 1'b0};
    vecs[3]  = '{8'd68,  8'd70,  2'b00, 1'b0, 1'b0};
    vecs[4]  = '{8'd72,  8'd70,  2'b00, 1'b0, 1'b0};
    vecs[5]  = '{8'd67,  8'd70,  2'b01, 1'b1, 1'b0};
    vecs[6]  = '{8'd69,  8'd70,  2'b01, 1'b1, 1'b0};
    vecs[7]  = '{8'd72,  8'd70,  2'b00, 1'b0, 1'b0};
    vecs[8]  = '{8'd0,   8'd1,   2'b00, 1'b0, 1'b0};
    vecs[9]  = '{8'd255, 8'd254, 2'b00, 1'b0, 1'b0};
    vecs[10] = '{8'd251, 8'd254, 2'b01, 1'b1, 1'b0};
    vecs[11] = '{8'd254, 8'd254, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{8'd4,   8'd1,   2'b10, 1'b0, 1'b1};
    vecs[13] = '{8'd1,   8'd1,   2'b00, 1'b0, 1'b0};
    vecs[14] = '{8'd70,  8'd70,  2'b00, 1'b0, 1'b0};

    reset       = 1'b1;
    temp_in     = 8'd0;
    temp_valid  = 1'b0;
    setpoint    = 8'd70;
    error_clear = 1'b0;
    tick(2);
    check_out("reset", 2'b00, 1'b0, 1'b0);
    check("reset.dwell", {31'd0, dwell_active}, 32'd0);
    reset = 1'b0;

    // Heat entry two cycles after the sample, then dwell holds HEAT until it expires.
    pulse(8'd65, 8'd70);
    tick(1);
    check_out("heat_entry", 2'b01, 1'b1, 1'b0);
    check("heat_entry.dwell", {31'd0, dwell_active}, 32'd1);
    pulse(8'd70, 8'd70);
    tick(1);
    check_out("heat_dwell_hold", 2'b01, 1'b1, 1'b0);
    tick(1);
    check_out("heat_exit", 2'b00, 1'b0, 1'b0);
    tick(2);

    for (int i = 0; i < 15; i++) begin
      pulse(vecs[i].temp, vecs[i].sp);
      tick(1);
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].heat, vecs[i].cool);
      tick(2);
    end

    // Sensor stops while heating: error visible 21 cycles after the last valid.
    pulse(8'd65, 8'd70);
    tick(19);
    check_out("wd_pre_timeout", 2'b01, 1'b1, 1'b0);
    tick(1);
    check_out("wd_timeout", 2'b11, 1'b0, 1'b0);

    @(negedge clk);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check_out("clear_no_sample", 2'b11, 1'b0, 1'b0);

    pulse(8'd70, 8'd70);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check_out("clear_with_sample", 2'b00, 1'b0, 1'b0);

    // Valid arriving exactly on the watchdog's final count prevents the error.
    tick(17);
    pulse(8'd70, 8'd70);
    tick(1);
    check_out("wd_coincident", 2'b00, 1'b0, 1'b0);
    tick(3);
    check_out("wd_coincident_later", 2'b00, 1'b0, 1'b0);

    // Asynchronous reset while cooling.
    pulse(8'd75, 8'd70);
    tick(1);
    check_out("cool_before_reset", 2'b10, 1'b0, 1'b1);
    tick(1);
    reset = 1'b1;
    #1;
    check_out("async_reset", 2'b00, 1'b0, 1'b0);
    check("async_reset.dwell", {31'd0, dwell_active}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(15);
    check_out("post_reset_idle", 2'b00, 1'b0, 1'b0);
    check("post_reset_idle.dwell", {31'd0, dwell_active}, 32'd0);
    tick(4);
    check_out("post_reset_pre_timeout", 2'b00, 1'b0, 1'b0);
    tick(1);
    check_out("post_reset_timeout", 2'b11, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
